// File: rtl/gyro_capture_ctrl.sv
// Gyro capture sequencer: on arm, clears the buffer, waits for a trigger, then forwards cap_len samples.
// Optional ARMED timeout is enabled by defining GYRO_CAPTURE_TIMEOUT_EN.
module gyro_capture_ctrl #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH          = 14,
    parameter int unsigned CLR_CYCLES         = 4,
    parameter int unsigned TIMEOUT_WIDTH      = 24
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          arm,
    input  logic                          abort,
    input  logic                          trig,
    input  logic [LEN_WIDTH-1:0]          cap_len,
    input  logic [TIMEOUT_WIDTH-1:0]      timeout_cycles,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          buf_rstn,
    output logic [2:0]                    state,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_flag,
    output logic [LEN_WIDTH-1:0]          sample_cnt,
    output logic [15:0]                   drop_cnt
);

    localparam int unsigned DROP_W = 16;
    localparam int unsigned CLR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic [LEN_WIDTH-1:0] cap_len_q, cap_len_d;
    logic [LEN_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
    logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                 buf_rstn_q, busy_q, done_q;
    logic                 fwd_valid, start, abort_hit, arm_ok, last_beat;
    logic                 unused_in;

`ifdef GYRO_CAPTURE_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                     tflag_q, tflag_d;
    assign timeout_flag = tflag_q;
    assign unused_in    = s_axis_tlast;
`else
    assign timeout_flag = 1'b0;
    assign unused_in    = s_axis_tlast ^ (^timeout_cycles);
`endif

    // Sensor is never stalled; data passes straight through while forwarding
    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = fwd_valid;
    assign m_axis_tlast  = fwd_valid & last_beat;

    assign state      = state_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign buf_rstn   = buf_rstn_q;
    assign sample_cnt = sample_cnt_q;
    assign drop_cnt   = drop_cnt_q;

    assign arm_ok    = arm && (cap_len != '0);
    assign abort_hit = abort && (state_q != S_IDLE);
    assign last_beat = (sample_cnt_q == (cap_len_q - LEN_WIDTH'(1)));

    // Next-state and counter update
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        cap_len_d    = cap_len_q;
        sample_cnt_d = sample_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        fwd_valid    = 1'b0;
        start        = 1'b0;
`ifdef GYRO_CAPTURE_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        tflag_d      = tflag_q;
`endif

        case (state_q)
            S_IDLE: start = arm_ok;
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = S_ARMED;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            S_ARMED: begin
                if (trig && s_axis_tvalid) begin
                    fwd_valid = 1'b1;
                    state_d   = S_CAPTURE;
                end
`ifdef GYRO_CAPTURE_TIMEOUT_EN
                else if (timeout_cycles != '0) begin
                    if (tmo_cnt_q == (timeout_cycles - TIMEOUT_WIDTH'(1))) begin
                        state_d = S_IDLE;
                        tflag_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
                    end
                end
`endif
            end
            S_CAPTURE: fwd_valid = s_axis_tvalid;
            S_DONE:    start = arm_ok;
            default:   state_d = S_IDLE;
        endcase

        // Abort abandons the cycle: nothing forwarded, no restart
        if (abort_hit) begin
            fwd_valid = 1'b0;
            start     = 1'b0;
        end

        if (start) begin
            state_d      = S_CLEAR;
            cap_len_d    = cap_len;
            sample_cnt_d = '0;
            drop_cnt_d   = '0;
            clr_cnt_d    = '0;
`ifdef GYRO_CAPTURE_TIMEOUT_EN
            tmo_cnt_d    = '0;
            tflag_d      = 1'b0;
`endif
        end

        if (fwd_valid) begin
            if (m_axis_tready) begin
                sample_cnt_d = sample_cnt_q + LEN_WIDTH'(1);
                if (last_beat) state_d = S_DONE;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end

        if (abort_hit) begin
            state_d = S_IDLE;
`ifdef GYRO_CAPTURE_TIMEOUT_EN
            tflag_d = tflag_q;
`endif
        end
    end

    // State and registered status
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            cap_len_q    <= '0;
            sample_cnt_q <= '0;
            drop_cnt_q   <= '0;
            buf_rstn_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef GYRO_CAPTURE_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            tflag_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            cap_len_q    <= cap_len_d;
            sample_cnt_q <= sample_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            buf_rstn_q   <= (state_d != S_CLEAR);
            busy_q       <= (state_d == S_CLEAR) || (state_d == S_ARMED) || (state_d == S_CAPTURE);
            done_q       <= (state_d == S_DONE);
`ifdef GYRO_CAPTURE_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            tflag_q      <= tflag_d;
`endif
        end
    end

endmodule

// File: tb/tb_gyro_capture_ctrl.sv
// Bench for gyro_capture_ctrl: capture table with a beat scoreboard, plus abort/reset/edge/timeout sequences.
module tb_gyro_capture_ctrl;

    logic        clk, rstn, arm, abort, trig;
    logic [13:0] cap_len, sample_cnt;
    logic [23:0] timeout_cycles;
    logic [31:0] s_axis_tdata, m_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic        buf_rstn, busy, done, timeout_flag;
    logic [2:0]  state;
    logic [15:0] drop_cnt;

    gyro_capture_ctrl dut (
        .clk(clk), .rstn(rstn), .arm(arm), .abort(abort), .trig(trig),
        .cap_len(cap_len), .timeout_cycles(timeout_cycles),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .buf_rstn(buf_rstn), .state(state), .busy(busy), .done(done),
        .timeout_flag(timeout_flag), .sample_cnt(sample_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    typedef struct {
        int unsigned len;
        int unsigned delay;
        int unsigned rdy_mode;
        int unsigned vld_mode;
        int unsigned exp_drops;
    } vec_t;

    beat_t       exp_q[$];
    vec_t        vecs[5];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] seq   = 32'hA500_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy_pat(input int unsigned m, input int unsigned i);
        case (m)
            0:       return 1'b1;
            1:       return (i % 2) == 1;
            default: return (i % 3) != 2;
        endcase
    endfunction

    function automatic logic vld_pat(input int unsigned m, input int unsigned i);
        if (m == 0) return 1'b1;
        return (i % 4) != 1;
    endfunction

    // Scoreboard: every accepted beat must match the next expected one
    always @(negedge clk) begin
        if (!buf_rstn) chk("tvalid_during_clear", {31'd0, m_axis_tvalid}, 32'd0);
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got data %0h with none expected (t=%0t)", m_axis_tdata, $time);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", m_axis_tdata, e.data);
                chk("beat_last", {31'd0, m_axis_tlast}, {31'd0, e.last});
            end
        end
    end

    task automatic do_arm(input logic [13:0] len, input bit chk_clear);
        int low;
        bit ok;
        @(posedge clk); #1; arm = 1'b1; cap_len = len; trig = 1'b0;
        @(posedge clk); #1; arm = 1'b0;
        low = 0;
        ok  = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (state == 3'd2) ok = 1'b1;
            else if (!buf_rstn) low++;
        end
        chk("reach_armed", {31'd0, ok}, 32'd1);
        if (chk_clear) begin
            chk("clear_cycles", low, 32'd4);
            chk("busy_armed", {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic run_row(input vec_t v);
        bit          armed_m, cap_m;
        int unsigned cnt, i;
        logic        vv, rr;
        do_arm(14'(v.len), 1'b1);
        for (int k = 0; k < int'(v.delay); k++) begin
            @(posedge clk); #1;
            trig = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = seq; seq++; m_axis_tready = 1'b1;
        end
        armed_m = 1'b1; cap_m = 1'b0; cnt = 0; i = 0;
        while ((armed_m || cap_m) && i < 400) begin
            @(posedge clk); #1;
            vv = vld_pat(v.vld_mode, i);
            rr = rdy_pat(v.rdy_mode, i);
            trig = 1'b1; s_axis_tvalid = vv; s_axis_tdata = seq; m_axis_tready = rr;
            if (vv) begin
                armed_m = 1'b0;
                cap_m   = 1'b1;
                if (rr) begin
                    exp_q.push_back('{seq, cnt == v.len - 1});
                    cnt++;
                    if (cnt == v.len) cap_m = 1'b0;
                end
            end
            seq++;
            i++;
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b1; s_axis_tdata = seq; seq++;
        @(negedge clk);
        chk("row_state_done", {29'd0, state}, 32'd4);
        chk("row_done", {31'd0, done}, 32'd1);
        chk("row_busy", {31'd0, busy}, 32'd0);
        chk("row_sample_cnt", {18'd0, sample_cnt}, v.len);
        chk("row_drop_cnt", {16'd0, drop_cnt}, v.exp_drops);
        chk("row_pending", exp_q.size(), 32'd0);
        @(posedge clk); #1; trig = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8, 3, 0, 0, 0};
        vecs[1] = '{16, 0, 1, 0, 16};
        vecs[2] = '{1, 2, 0, 0, 0};
        vecs[3] = '{5, 1, 2, 1, 1};
        vecs[4] = '{3, 0, 1, 1, 6};

        rstn = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0; cap_len = '0;
        timeout_cycles = '0; s_axis_tdata = '0; s_axis_tvalid = 1'b1;
        s_axis_tlast = 1'b0; m_axis_tready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_buf_rstn", {31'd0, buf_rstn}, 32'd0);
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_tflag", {31'd0, timeout_flag}, 32'd0);
        chk("rst_counts", {sample_cnt, drop_cnt}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("buf_rstn_release", {31'd0, buf_rstn}, 32'd1);

        // cap_len = 0 arm is ignored
        @(posedge clk); #1; arm = 1'b1; cap_len = '0;
        @(posedge clk); #1; arm = 1'b0;
        @(negedge clk);
        chk("zero_len_state", {29'd0, state}, 32'd0);
        chk("zero_len_busy", {31'd0, busy}, 32'd0);

        foreach (vecs[r]) run_row(vecs[r]);

        // Abort after 5 of 100 captured samples
        do_arm(14'd100, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            trig = 1'b1; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1; s_axis_tdata = seq;
            exp_q.push_back('{seq, 1'b0});
            seq++;
        end
        @(posedge clk); #1; trig = 1'b0; s_axis_tvalid = 1'b0; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0; s_axis_tvalid = 1'b1;
        @(negedge clk);
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_sample_cnt", {18'd0, sample_cnt}, 32'd5);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_buf_rstn", {31'd0, buf_rstn}, 32'd1);
        chk("abort_pending", exp_q.size(), 32'd0);

        // ARMED waits with no trigger, then arm+abort together returns to IDLE
        do_arm(14'd2, 1'b0);
        repeat (150) begin
            @(posedge clk); #1; trig = 1'b0; s_axis_tdata = seq; seq++;
        end
        @(negedge clk);
        chk("armed_hold_state", {29'd0, state}, 32'd2);
        chk("armed_hold_tflag", {31'd0, timeout_flag}, 32'd0);
        @(posedge clk); #1; arm = 1'b1; abort = 1'b1; cap_len = 14'd7;
        @(posedge clk); #1; arm = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("arm_abort_state", {29'd0, state}, 32'd0);
        chk("arm_abort_buf_rstn", {31'd0, buf_rstn}, 32'd1);

        // Reset mid-capture drops straight to IDLE with the buffer held in reset
        do_arm(14'd50, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            trig = 1'b1; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1; s_axis_tdata = seq;
            exp_q.push_back('{seq, 1'b0});
            seq++;
        end
        @(posedge clk); #1; rstn = 1'b0; trig = 1'b0;
        #1;
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_buf_rstn", {31'd0, buf_rstn}, 32'd0);
        chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("midrst_pending", exp_q.size(), 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        chk("midrst_release", {31'd0, buf_rstn}, 32'd1);

`ifdef GYRO_CAPTURE_TIMEOUT_EN
        begin
            int n;
            timeout_cycles = 24'd100;
            do_arm(14'd4, 1'b0);
            n = 1;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (state == 3'd2) n++;
                else break;
            end
            chk("tmo_armed_cycles", n, 32'd100);
            chk("tmo_state", {29'd0, state}, 32'd0);
            chk("tmo_flag_set", {31'd0, timeout_flag}, 32'd1);
            timeout_cycles = '0;
            do_arm(14'd4, 1'b0);
            chk("tmo_flag_cleared", {31'd0, timeout_flag}, 32'd0);
            @(posedge clk); #1; abort = 1'b1;
            @(posedge clk); #1; abort = 1'b0;
        end
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
